// File: rtl/mipi_csi_packet_encoder.sv
`default_nettype none
// ============================================================================
// Module      : mipi_csi_packet_encoder
// Description : CSI-2 short/long packet builder for a 4-lane HS byte stream,
//               32 bits (one byte per lane) per clock.  Emits the SoT sync
//               word, the packet header with Hamming ECC, the payload and the
//               CRC-16 footer, then holds the link low for a fixed gap.
//
// Ports
//   clk_i         byte clock (single domain)
//   reset_n_i     asynchronous active-low reset
//   cmd_valid_i   packet request valid
//   cmd_ready_o   encoder idle; request taken on valid & ready
//   cmd_vc_i      virtual channel  -> DI[7:6]
//   cmd_dt_i      data type        -> DI[5:0]; dt >= 0x10 is a long packet
//   cmd_wc_i      long: payload byte count, short: 16-bit data field
//   data_i        payload beat, [7:0] is the first byte (lane 0)
//   data_valid_i  payload beat valid
//   data_ready_o  a beat is loaded on this edge if data_valid_i is high
//   hs_data_o     lane bytes, lane n = [8n+7:8n]
//   hs_valid_o    HS burst active
//   lane_en_o     per-lane byte valid
//   error_o       sticky: [0] payload underrun, [1] misaligned long WC
//
// Revision    : 1.0  initial release
// ============================================================================
module mipi_csi_packet_encoder #(
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_vc_i,
    input  logic [5:0]  cmd_dt_i,
    input  logic [15:0] cmd_wc_i,
    input  logic [31:0] data_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic [31:0] hs_data_o,
    output logic        hs_valid_o,
    output logic [3:0]  lane_en_o,
    output logic [1:0]  error_o
);

    localparam int          c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // The IDLE cycle in which the next command is taken is itself one of the
    // low cycles, so the GAP state only covers GAP_CYCLES-1 of them.  This
    // keeps back-to-back packets exactly GAP_CYCLES low cycles apart.
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'((GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0);
    localparam logic [31:0] c_SYNC     = 32'hB8B8_B8B8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_FOOTER  = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

    state_t               r_state;
    logic [7:0]           r_di;
    logic [15:0]          r_wc;
    logic                 r_long;
    logic [13:0]          r_beat_cnt;
    logic [15:0]          r_crc;
    logic [c_GAP_W-1:0]   r_gap_cnt;

    logic [7:0]           w_ecc;
    logic [31:0]          w_beat;
    logic                 w_last_beat;
    logic [13:0]          w_beats;

    // ------------------------------------------------------------------
    // 6-bit Hamming ECC over {WC, DI}; the top two ECC bits are zero.
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return {2'b00, p};
    endfunction

    // ------------------------------------------------------------------
    // Reflected CRC-16 (poly 0x8408) byte update in closed form:
    // x = lo(crc)^b; x ^= x<<4; crc = (x<<8 | hi(crc)) ^ (x>>4) ^ (x<<3)
    // ------------------------------------------------------------------
    function automatic logic [15:0] f_crc_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [7:0] x;
        x = crc[7:0] ^ b;
        x = x ^ {x[3:0], 4'b0000};
        return {x, crc[15:8]} ^ {12'h000, x[7:4]} ^ {5'b00000, x, 3'b000};
    endfunction

    // Lane 0 is the first byte on the wire, so it is folded in first.
    function automatic logic [15:0] f_crc_word(input logic [15:0] crc, input logic [31:0] w);
        logic [15:0] c;
        c = f_crc_byte(crc, w[7:0]);
        c = f_crc_byte(c, w[15:8]);
        c = f_crc_byte(c, w[23:16]);
        c = f_crc_byte(c, w[31:24]);
        return c;
    endfunction

    assign w_ecc       = f_ecc({r_wc, r_di});
    assign w_beats     = r_wc[15:2];
    assign w_last_beat = (r_beat_cnt == (w_beats - 14'd1));
    // The HS link cannot stall: a missing beat goes out as zeros.
    assign w_beat      = data_valid_i ? data_i : 32'h0000_0000;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= ST_IDLE;
            r_di         <= 8'h00;
            r_wc         <= 16'h0000;
            r_long       <= 1'b0;
            r_beat_cnt   <= 14'd0;
            r_crc        <= 16'hFFFF;
            r_gap_cnt    <= '0;
            cmd_ready_o  <= 1'b1;
            data_ready_o <= 1'b0;
            hs_data_o    <= 32'h0000_0000;
            hs_valid_o   <= 1'b0;
            lane_en_o    <= 4'h0;
            error_o      <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    hs_data_o  <= 32'h0000_0000;
                    hs_valid_o <= 1'b0;
                    lane_en_o  <= 4'h0;
                    if (cmd_valid_i && cmd_ready_o) begin
                        r_di        <= {cmd_vc_i, cmd_dt_i};
                        r_wc        <= cmd_wc_i;
                        r_long      <= (cmd_dt_i >= 6'h10);
                        cmd_ready_o <= 1'b0;
                        r_state     <= ST_SYNC;
                    end
                end

                ST_SYNC: begin
                    hs_data_o  <= c_SYNC;
                    hs_valid_o <= 1'b1;
                    lane_en_o  <= 4'hF;
                    r_crc      <= 16'hFFFF;
                    r_beat_cnt <= 14'd0;
                    r_state    <= ST_HEADER;
                end

                ST_HEADER: begin
                    hs_data_o  <= {w_ecc, r_wc[15:8], r_wc[7:0], r_di};
                    hs_valid_o <= 1'b1;
                    lane_en_o  <= 4'hF;
                    if (!r_long) begin
                        if (GAP_CYCLES > 1) begin
                            r_gap_cnt <= c_GAP_LOAD;
                            r_state   <= ST_GAP;
                        end else begin
                            cmd_ready_o <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end else begin
                        if (r_wc[1:0] != 2'b00) begin
                            error_o[1] <= 1'b1;
                        end
                        if (w_beats != 14'd0) begin
                            // Ready is registered, so it must lead the first
                            // payload edge by one cycle.
                            data_ready_o <= 1'b1;
                            r_state      <= ST_PAYLOAD;
                        end else begin
                            r_state <= ST_FOOTER;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    hs_data_o  <= w_beat;
                    hs_valid_o <= 1'b1;
                    lane_en_o  <= 4'hF;
                    r_crc      <= f_crc_word(r_crc, w_beat);
                    r_beat_cnt <= r_beat_cnt + 14'd1;
                    if (!data_valid_i) begin
                        error_o[0] <= 1'b1;
                    end
                    if (w_last_beat) begin
                        data_ready_o <= 1'b0;
                        r_state      <= ST_FOOTER;
                    end
                end

                ST_FOOTER: begin
                    hs_data_o  <= {16'h0000, r_crc};
                    hs_valid_o <= 1'b1;
                    lane_en_o  <= 4'b0011;
                    if (GAP_CYCLES > 1) begin
                        r_gap_cnt <= c_GAP_LOAD;
                        r_state   <= ST_GAP;
                    end else begin
                        cmd_ready_o <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                ST_GAP: begin
                    hs_data_o  <= 32'h0000_0000;
                    hs_valid_o <= 1'b0;
                    lane_en_o  <= 4'h0;
                    if (r_gap_cnt == '0) begin
                        cmd_ready_o <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end

                default: begin
                    cmd_ready_o  <= 1'b1;
                    data_ready_o <= 1'b0;
                    hs_valid_o   <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
